// File: rtl/formant_pkg.sv
// Shared types and constants for the formant-tracking DP scheduler.
// Column width here matches the default frame size; modules derive their own from I.
package formant_pkg;

  localparam int unsigned I_MAX = 160;
  localparam int unsigned COL_W = $clog2(I_MAX);

  typedef logic [COL_W-1:0] col_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_WRCNT   = 2'd2;
  localparam logic [1:0] ERR_NUMI    = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_EMIN_GO,
    S_EMIN_WAIT,
    S_F_GO,
    S_F_WAIT,
    S_BT_GO,
    S_BT_WAIT,
    S_DONE,
    S_ERR
  } seq_state_t;

  // States in which the sequencer is waiting on a downstream unit.
  function automatic logic is_wait_state(input seq_state_t s);
    return (s == S_EMIN_WAIT) || (s == S_F_WAIT) || (s == S_BT_WAIT);
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Cycle watchdog for the sequencer WAIT states.
// Expired is raised during the TIMEOUT-th consecutive enabled cycle since the last clear.
module seq_watchdog #(
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign expired = enable && (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/formant_dp_sequencer.sv
// Column scheduler for the formant DP: drives Emin, F and backtrack units in turn.
// All outputs are registered from the current state, so they trail the state by one cycle.
module formant_dp_sequencer
  import formant_pkg::*;
#(
  parameter int unsigned I        = 160,
  parameter int unsigned FORMANTS = 5,
  parameter int unsigned TIMEOUT  = 4096
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start,
  input  logic                 abort,
  input  logic [$clog2(I)-1:0] num_i,
  output logic                 emin_start,
  output logic [$clog2(I)-1:0] emin_i,
  input  logic                 emin_done,
  output logic                 f_begin_iter,
  output logic [$clog2(I)-1:0] f_i,
  input  logic                 f_output_valid,
  input  logic                 f_iter_done,
  output logic                 bt_start,
  input  logic                 bt_done,
  output logic [$clog2(I)-1:0] cur_i,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [1:0]           err_code
);

  localparam int unsigned CW   = $clog2(I);
  localparam int unsigned WR_W = $clog2(TIMEOUT + 1);

  seq_state_t       r_state, w_state_nxt;
  logic [CW-1:0]    r_cur_i, w_cur_i_nxt;
  logic [CW-1:0]    r_num_i, w_num_i_nxt;
  logic [WR_W-1:0]  r_wr_cnt, w_wr_cnt_nxt;
  logic [1:0]       r_err, w_err_nxt;

  logic [WR_W-1:0]  w_wr_sum;
  logic [31:0]      w_exp;
  logic             w_last_col;
  logic             w_expired;
  logic             w_wd_clear;
  logic             w_in_wait;

  // A valid in the same cycle as iter_done is included in the compared count.
  assign w_wr_sum   = r_wr_cnt + WR_W'(f_output_valid);
  assign w_exp      = ((32'(r_cur_i) + 32'd1) < FORMANTS) ? (32'(r_cur_i) + 32'd1) : FORMANTS;
  assign w_last_col = (r_cur_i == (r_num_i - CW'(1)));
  assign w_in_wait  = is_wait_state(r_state);
  assign w_wd_clear = (w_state_nxt != r_state);

  seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .clear   (w_wd_clear),
    .enable  (w_in_wait),
    .expired (w_expired)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state  <= S_IDLE;
      r_cur_i  <= '0;
      r_num_i  <= '0;
      r_wr_cnt <= '0;
      r_err    <= ERR_NONE;
    end else begin
      r_state  <= w_state_nxt;
      r_cur_i  <= w_cur_i_nxt;
      r_num_i  <= w_num_i_nxt;
      r_wr_cnt <= w_wr_cnt_nxt;
      r_err    <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cur_i_nxt  = r_cur_i;
    w_num_i_nxt  = r_num_i;
    w_wr_cnt_nxt = r_wr_cnt;
    w_err_nxt    = r_err;

    if (abort) begin
      w_state_nxt = S_IDLE;
      w_cur_i_nxt = '0;
      w_err_nxt   = ERR_NONE;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            if (num_i == '0) begin
              w_state_nxt = S_ERR;
              w_err_nxt   = ERR_NUMI;
            end else begin
              w_state_nxt = S_EMIN_GO;
              w_num_i_nxt = num_i;
              w_cur_i_nxt = '0;
              w_err_nxt   = ERR_NONE;
            end
          end
        end
        S_EMIN_GO: w_state_nxt = S_EMIN_WAIT;
        S_EMIN_WAIT: begin
          if (emin_done) begin
            w_state_nxt = S_F_GO;
          end else if (w_expired) begin
            w_state_nxt = S_ERR;
            w_err_nxt   = ERR_TIMEOUT;
          end
        end
        S_F_GO: begin
          w_wr_cnt_nxt = '0;
          w_state_nxt  = S_F_WAIT;
        end
        S_F_WAIT: begin
          w_wr_cnt_nxt = w_wr_sum;
          if (f_iter_done) begin
            if (32'(w_wr_sum) != w_exp) begin
              w_state_nxt = S_ERR;
              w_err_nxt   = ERR_WRCNT;
            end else if (w_last_col) begin
              w_state_nxt = S_BT_GO;
            end else begin
              w_cur_i_nxt = r_cur_i + CW'(1);
              w_state_nxt = S_EMIN_GO;
            end
          end else if (w_expired) begin
            w_state_nxt = S_ERR;
            w_err_nxt   = ERR_TIMEOUT;
          end
        end
        S_BT_GO: w_state_nxt = S_BT_WAIT;
        S_BT_WAIT: begin
          if (bt_done) begin
            w_state_nxt = S_DONE;
          end else if (w_expired) begin
            w_state_nxt = S_ERR;
            w_err_nxt   = ERR_TIMEOUT;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Abort zeroes the outputs on the same edge that returns the FSM to IDLE.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      emin_start   <= 1'b0;
      f_begin_iter <= 1'b0;
      bt_start     <= 1'b0;
      emin_i       <= '0;
      f_i          <= '0;
      cur_i        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      err_code     <= ERR_NONE;
    end else if (abort) begin
      emin_start   <= 1'b0;
      f_begin_iter <= 1'b0;
      bt_start     <= 1'b0;
      emin_i       <= '0;
      f_i          <= '0;
      cur_i        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      err_code     <= ERR_NONE;
    end else begin
      emin_start   <= (r_state == S_EMIN_GO);
      f_begin_iter <= (r_state == S_F_GO);
      bt_start     <= (r_state == S_BT_GO);
      emin_i       <= r_cur_i;
      f_i          <= r_cur_i;
      cur_i        <= r_cur_i;
      busy         <= !((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
      done         <= (r_state == S_DONE);
      error        <= (r_state == S_ERR);
      err_code     <= r_err;
    end
  end

endmodule
